// File: rtl/conv_pad_inserter_if.sv
// Pixel stream bundle between the producer, the pad inserter and the convolution stage.
// The slave modport is the pad inserter's view; master is the producer/consumer side.
interface conv_pad_inserter_if #(
  parameter int PIXEL_DATAW = 8
);
  logic                   i_valid;
  logic [PIXEL_DATAW-1:0] i_x;
  logic                   i_last;
  logic                   i_ready;
  logic                   o_ready;
  logic                   o_valid;
  logic [PIXEL_DATAW-1:0] o_y;
  logic                   o_err;

  modport master (
    output i_valid, i_x, i_last, i_ready,
    input  o_ready, o_valid, o_y, o_err
  );

  modport slave (
    input  i_valid, i_x, i_last, i_ready,
    output o_ready, o_valid, o_y, o_err
  );
endinterface

// File: rtl/conv_pad_inserter.sv
// Wraps a raw image stream in a PAD-wide zero border; 1-cycle body pass-through, first zero 2 cycles after frame start.
// Downstream stall freezes outputs, state and counters; input is only accepted in BODY while the output can advance.
module conv_pad_inserter #(
  parameter int IMAGE_WIDTH = 512,
  parameter int PIXEL_DATAW = 8,
  parameter int PAD         = 1
) (
  input logic                clk,
  input logic                reset_n,
  conv_pad_inserter_if.slave bus
);
  localparam int BOARD_WIDTH = IMAGE_WIDTH + 2 * PAD;
  localparam int CW          = $clog2(BOARD_WIDTH);
  localparam int PW          = $clog2(PAD + 1);

  localparam logic [CW-1:0] ROW_END  = CW'(BOARD_WIDTH - 1);
  localparam logic [CW-1:0] BODY_END = CW'(IMAGE_WIDTH - 1);
  localparam logic [CW-1:0] SIDE_END = CW'(PAD - 1);
  localparam logic [PW-1:0] PROW_END = PW'(PAD - 1);

  typedef enum logic [2:0] {
    IDLE,
    TOP,
    LEFT,
    BODY,
    RIGHT,
    BOTTOM
  } state_t;

  state_t                 state, state_nx;
  logic [CW-1:0]          col, col_nx;
  logic [PW-1:0]          padrow, padrow_nx;
  logic                   last_row, last_row_nx;
  logic [PIXEL_DATAW-1:0] y_q, y_nx;
  logic                   vld_q, vld_nx;
  logic                   err_q, err_nx;
  logic                   advance;

  assign advance     = ~vld_q | bus.i_ready;
  assign bus.o_ready = advance && (state == BODY);
  assign bus.o_valid = vld_q;
  assign bus.o_y     = y_q;
  assign bus.o_err   = err_q;

  always_comb begin
    state_nx    = state;
    col_nx      = col;
    padrow_nx   = padrow;
    last_row_nx = last_row;
    y_nx        = y_q;
    vld_nx      = vld_q;
    err_nx      = err_q;

    if (advance) begin
      unique case (state)
        IDLE: begin
          vld_nx = 1'b0;
          // The waiting pixel is not consumed here; it is taken once BODY is reached.
          if (bus.i_valid) begin
            state_nx  = TOP;
            col_nx    = '0;
            padrow_nx = '0;
          end
        end
        TOP, BOTTOM: begin
          vld_nx = 1'b1;
          y_nx   = '0;
          if (col == ROW_END) begin
            col_nx = '0;
            if (padrow == PROW_END) begin
              padrow_nx = '0;
              if (state == TOP) begin
                state_nx = LEFT;
              end else begin
                state_nx    = IDLE;
                last_row_nx = 1'b0;
              end
            end else begin
              padrow_nx = padrow + 1'b1;
            end
          end else begin
            col_nx = col + 1'b1;
          end
        end
        LEFT, RIGHT: begin
          vld_nx = 1'b1;
          y_nx   = '0;
          if (col == SIDE_END) begin
            col_nx = '0;
            if (state == LEFT) state_nx = BODY;
            else               state_nx = last_row ? BOTTOM : LEFT;
          end else begin
            col_nx = col + 1'b1;
          end
        end
        BODY: begin
          if (bus.i_valid) begin
            vld_nx = 1'b1;
            y_nx   = bus.i_x;
            if (col == BODY_END) begin
              col_nx      = '0;
              state_nx    = RIGHT;
              last_row_nx = bus.i_last;
            end else begin
              col_nx = col + 1'b1;
              // A mid-row last marker is flagged and otherwise ignored.
              if (bus.i_last) err_nx = 1'b1;
            end
          end else begin
            vld_nx = 1'b0;
          end
        end
        default: begin
          state_nx = IDLE;
          vld_nx   = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= IDLE;
      col      <= '0;
      padrow   <= '0;
      last_row <= 1'b0;
      y_q      <= '0;
      vld_q    <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state    <= state_nx;
      col      <= col_nx;
      padrow   <= padrow_nx;
      last_row <= last_row_nx;
      y_q      <= y_nx;
      vld_q    <= vld_nx;
      err_q    <= err_nx;
    end
  end
endmodule
